// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: instruction memory port, decode-side valid/ready head, and redirect.
// The master side is the fetch queue; the slave side is memory/decoder/writeback.
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              dec_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output mem_addr, mem_rd, instr, instr_pc, instr_valid, occupancy,
    input  mem_data, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_rd, instr, instr_pc, instr_valid, occupancy,
    output mem_data, dec_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues to a synchronous-read memory,
// buffers returned words with their PCs, and flushes everything on redirect.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic           CLK,
  input  logic           RST,
  fetch_queue_if.master  fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] reqPc;
  logic              reqValid;
  logic [DATA_W-1:0] instrMem [DEPTH];
  logic [ADDR_W-1:0] pcMem    [DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CW-1:0]     count;

  logic [CW:0]       pending;
  logic              issue;
  logic              push;
  logic              pop;

  // Issue counts the in-flight word against free space, ignoring a concurrent pop.
  always_comb begin
    pending = {1'b0, count} + {{CW{1'b0}}, reqValid};
    issue   = RST && !fq.redirect && (pending < (CW+1)'(DEPTH));
    push    = reqValid && !fq.redirect;
    pop     = (count != '0) && fq.dec_ready && !fq.redirect;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fpc      <= '0;
      reqPc    <= '0;
      reqValid <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else if (fq.redirect) begin
      fpc      <= fq.redirect_pc;
      reqValid <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else begin
      reqValid <= issue;
      if (issue) begin
        reqPc <= fpc;
        fpc   <= fpc + ADDR_W'(1);
      end
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge CLK) begin
    if (push) begin
      instrMem[wrPtr] <= fq.mem_data;
      pcMem[wrPtr]    <= reqPc;
    end
  end

  assign fq.mem_addr    = fpc;
  assign fq.mem_rd      = issue;
  assign fq.instr       = instrMem[rdPtr];
  assign fq.instr_pc    = pcMem[rdPtr];
  assign fq.instr_valid = (count != '0);
  assign fq.occupancy   = count;

  noOverflow: assert property (@(posedge CLK) disable iff (!RST)
    !(push && !pop && (count == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed timing scenarios plus a randomized
// run checked against a PC-stream scoreboard.
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   testsRun = 0;
  int   failed   = 0;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .fq  (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    return 16'hA000 + {4'h0, a};
  endfunction

  // Synchronous-read instruction memory: data appears the cycle after the issuing edge.
  always @(posedge CLK) begin
    if (bus.mem_rd) bus.mem_data <= word(bus.mem_addr);
  end

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Holds reset for a few edges, releases it, and returns sampling cycle 0.
  task automatic resetStart();
    RST = 1'b0;
    cyc(); cyc(); cyc();
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    bus.dec_ready = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0;
    RST = 1'b0;
    cyc(); cyc();
    #1;
    testsRun++; if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
    testsRun++; if (bus.occupancy !== 3'd0) begin failed++; $display("FAIL reset_occ got %0d want 0", bus.occupancy); end
    testsRun++; if (bus.mem_rd !== 1'b0) begin failed++; $display("FAIL reset_memrd got %b want 0", bus.mem_rd); end
    testsRun++; if (bus.mem_addr !== 12'h000) begin failed++; $display("FAIL reset_addr got %h want 000", bus.mem_addr); end
  endtask

  task automatic test_stream();
    bus.dec_ready = 1'b1; bus.redirect = 1'b0;
    resetStart();
    testsRun++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h000) begin failed++; $display("FAIL stream_c0 got rd=%b addr=%h want rd=1 addr=000", bus.mem_rd, bus.mem_addr); end
    cyc(); #1;
    testsRun++; if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL stream_c1 got valid=%b want 0", bus.instr_valid); end
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      testsRun++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'(k) || bus.instr !== word(12'(k))) begin
        failed++;
        $display("FAIL stream_seq%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 12'(k), word(12'(k)));
      end
    end
  endtask

  task automatic test_backpressure();
    bus.dec_ready = 1'b0; bus.redirect = 1'b0;
    resetStart();
    for (int c = 1; c < 10; c++) begin
      cyc(); #1;
      if (c >= 2) begin
        testsRun++;
        if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA000 || bus.instr_pc !== 12'h000) begin
          failed++; $display("FAIL bp_hold_c%0d got v=%b ins=%h pc=%h want v=1 ins=a000 pc=000", c, bus.instr_valid, bus.instr, bus.instr_pc);
        end
      end
      if (c >= 4) begin
        testsRun++; if (bus.mem_rd !== 1'b0) begin failed++; $display("FAIL bp_memrd_c%0d got %b want 0", c, bus.mem_rd); end
      end
    end
    testsRun++; if (bus.occupancy !== 3'd4) begin failed++; $display("FAIL bp_occ got %0d want 4", bus.occupancy); end
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.dec_ready = 1'b1;
      #1;
      testsRun++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'(k) || bus.instr !== word(12'(k))) begin
        failed++; $display("FAIL bp_drain%0d got v=%b pc=%h ins=%h want v=1 pc=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, 12'(k));
      end
    end
  endtask

  // Checks r+1..r+3 after a redirect raised in the current cycle, then nChk accepted PCs.
  task automatic redirectTail(input string nm, input logic [ADDR_W-1:0] tgt, input int nChk);
    cyc(); bus.redirect = 1'b0; #1;
    testsRun++; if (bus.instr_valid !== 1'b0 || bus.occupancy !== 3'd0) begin failed++; $display("FAIL %s_r1 got v=%b occ=%0d want v=0 occ=0", nm, bus.instr_valid, bus.occupancy); end
    testsRun++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== tgt) begin failed++; $display("FAIL %s_issue got rd=%b addr=%h want rd=1 addr=%h", nm, bus.mem_rd, bus.mem_addr, tgt); end
    cyc(); #1;
    testsRun++; if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL %s_r2 got v=%b want 0", nm, bus.instr_valid); end
    for (int k = 0; k < nChk; k++) begin
      cyc(); bus.dec_ready = 1'b1; #1;
      testsRun++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== tgt + 12'(k) || bus.instr !== word(tgt + 12'(k))) begin
        failed++; $display("FAIL %s_seq%0d got v=%b pc=%h ins=%h want v=1 pc=%h", nm, k, bus.instr_valid, bus.instr_pc, bus.instr, tgt + 12'(k));
      end
    end
  endtask

  task automatic test_redirect();
    bus.dec_ready = 1'b0; bus.redirect = 1'b0;
    resetStart();
    cyc(); cyc(); cyc();
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 12'h120; #1;
    testsRun++; if (bus.occupancy !== 3'd3) begin failed++; $display("FAIL redir_pre_occ got %0d want 3", bus.occupancy); end
    testsRun++; if (bus.mem_rd !== 1'b0) begin failed++; $display("FAIL redir_noissue got %b want 0", bus.mem_rd); end
    redirectTail("redir", 12'h120, 5);
  endtask

  task automatic test_redirect_pop();
    bus.dec_ready = 1'b1; bus.redirect = 1'b0;
    resetStart();
    for (int c = 1; c < 5; c++) cyc();
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 12'h300; #1;
    testsRun++; if (bus.instr_valid !== 1'b1) begin failed++; $display("FAIL rpop_pre got v=%b want 1", bus.instr_valid); end
    redirectTail("rpop", 12'h300, 3);
  endtask

  task automatic test_wrap();
    cyc(); bus.dec_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 12'hFFE; #1;
    redirectTail("wrap", 12'hFFE, 4);
  endtask

  task automatic test_reset_mid();
    bus.dec_ready = 1'b0; bus.redirect = 1'b0;
    resetStart();
    cyc(); cyc(); cyc(); #1;
    testsRun++; if (bus.occupancy !== 3'd2) begin failed++; $display("FAIL rmid_pre_occ got %0d want 2", bus.occupancy); end
    #2;
    RST = 1'b0;
    #1;
    testsRun++;
    if (bus.instr_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.mem_addr !== 12'h000 || bus.mem_rd !== 1'b0) begin
      failed++; $display("FAIL rmid_async got v=%b occ=%0d addr=%h rd=%b want 0/0/000/0", bus.instr_valid, bus.occupancy, bus.mem_addr, bus.mem_rd);
    end
    bus.dec_ready = 1'b1;
    resetStart();
    cyc(); cyc(); #1;
    testsRun++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 12'h000 || bus.instr !== 16'hA000) begin failed++; $display("FAIL rmid_first got v=%b pc=%h ins=%h want v=1 pc=000 ins=a000", bus.instr_valid, bus.instr_pc, bus.instr); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] expPc;
    logic [ADDR_W-1:0] prevPc;
    logic [DATA_W-1:0] prevInstr;
    logic              prevHold;
    int                age;
    bus.dec_ready = 1'b1; bus.redirect = 1'b0;
    resetStart();
    expPc = '0; prevHold = 1'b0; prevPc = '0; prevInstr = '0; age = 100;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      bus.dec_ready   = ($urandom_range(0, 9) < 6);
      bus.redirect    = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = 12'($urandom);
      #1;
      if (age < 100) age++;
      if (prevHold) begin
        testsRun++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== prevPc || bus.instr !== prevInstr) begin
          failed++; $display("FAIL rnd_stable@%0d got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, bus.instr_valid, bus.instr_pc, bus.instr, prevPc, prevInstr);
        end
      end
      if (age == 1 || age == 2) begin
        testsRun++; if (bus.instr_valid !== 1'b0) begin failed++; $display("FAIL rnd_flush@%0d age=%0d got v=%b want 0", i, age, bus.instr_valid); end
      end
      if (age == 3) begin
        testsRun++; if (bus.instr_valid !== 1'b1) begin failed++; $display("FAIL rnd_refill@%0d got v=%b want 1", i, bus.instr_valid); end
      end
      testsRun++; if (bus.occupancy > 3'd4) begin failed++; $display("FAIL rnd_occ@%0d got %0d want <=4", i, bus.occupancy); end
      if (bus.instr_valid && bus.dec_ready && !bus.redirect) begin
        testsRun++;
        if (bus.instr_pc !== expPc || bus.instr !== word(expPc)) begin
          failed++; $display("FAIL rnd_order@%0d got pc=%h ins=%h want pc=%h ins=%h", i, bus.instr_pc, bus.instr, expPc, word(expPc));
        end
        expPc = expPc + 12'd1;
      end
      prevHold  = bus.instr_valid && !bus.dec_ready && !bus.redirect;
      prevPc    = bus.instr_pc;
      prevInstr = bus.instr;
      if (bus.redirect) begin
        expPc = bus.redirect_pc;
        age   = 0;
      end
    end
    cyc();
    bus.redirect = 1'b0; bus.dec_ready = 1'b1;
  endtask

  initial begin
    bus.dec_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end
endmodule
